frame_painter: RTL and testbench
================================

// Module: frame_painter
// PURPOSE
//  Parametrised successor to the single-frame pixel painter. Each frame it draws the player
//  box and NUM_PIPES pipe columns, then waits for the game tick. It then erases the same pixels.
//  Sits between game logic (positions, collided, game_pulse) and the VGA adapter (plot/x/y/colour).
//  New capability: N pipes, rectangular pipes, snapshot-based erase, sticky tick, done/busy outputs.
// PARAMETERS
//  NUM_PIPES   3    number of pipe columns painted per pass (1..8)
//  PIPE_LEN    30   pipe height in pixels (rows from pipe_y downward)
//  PIPE_W      1    pipe width in pixels
//  BOX_SIZE    3    player box edge in pixels (square)
//  BOX_X       4    fixed x of box top-left corner
//  X_W         9    x coordinate width
//  Y_W         7    y coordinate width
//  SCREEN_H    120  visible rows (used only with FRAME_PAINTER_CLIP_EN)
// PORTS
//  CLOCK_50     in   1              system clock, all logic posedge
//  reset        in   1              asynchronous, active-high
//  key_press    in   1              start request, sampled only in START
//  game_pulse   in   1              game tick, one-cycle pulse
//  collided     in   1              sampled only in DONE
//  box_y        in   Y_W            box top-left y
//  pipe_x       in   NUM_PIPES*X_W  pipe i x at [i*X_W +: X_W]
//  pipe_y       in   NUM_PIPES*Y_W  pipe i top y at [i*Y_W +: Y_W]
//  plot         out  1              pixel write strobe; x/y/colour valid when high
//  x            out  X_W            pixel x
//  y            out  Y_W            pixel y
//  colour       out  3              RGB: RED 3'b100 box, GREEN 3'b010 pipes, BLACK 3'b000 erase
//  frame_done   out  1              one-cycle pulse after each erase pass completes
//  busy         out  1              high during LATCH/DRAW/ERASE passes
// BEHAVIOUR
//  - Reset: state START; plot, x, y, colour, frame_done, busy = 0; tick_pending = 0.
//  - All outputs are registered. One pixel per clock. No gaps inside a pass.
//  - States: START -> (key_press) LATCH -> DRAW -> WAIT -> (tick) ERASE -> DONE
//    -> (collided ? START : LATCH).
//  - LATCH (1 cycle, plot=0): snapshot box_y, pipe_x, pipe_y into internal regs.
//    Both passes use only this snapshot.
//  - DRAW: box first, row-major from (BOX_X, box_y), RED. Then pipes 0..NUM_PIPES-1.
//    Each pipe is column-major: x = px..px+PIPE_W-1, y = py..py+PIPE_LEN-1, GREEN.
//    Pass length P = BOX_SIZE^2 + NUM_PIPES*PIPE_W*PIPE_LEN cycles (99 at defaults).
//  - ERASE: identical pixel order and coordinates as DRAW, colour BLACK, P cycles.
//  - DONE (1 cycle, plot=0): frame_done=1; collided sampled here.
//  - busy=1 from LATCH entry through last ERASE pixel; 0 in START, WAIT, DONE.
//  - Tick: game_pulse in any state except START sets tick_pending. WAIT exits to ERASE on
//    (game_pulse | tick_pending) and clears tick_pending. A pulse during DRAW is never lost.
//    Multiple pulses before WAIT collapse to one.
//  - key_press outside START is ignored. game_pulse in START is ignored.
//  - Arithmetic: y = base + offset, truncated mod 2^Y_W. x = base + offset, truncated mod 2^X_W.
//  - Reset mid-pass: immediate return to START with plot=0. No erase of partial frame.
// CONFIGURATION
//  FRAME_PAINTER_CLIP_EN defined:
//   - Pixels with unwrapped y >= SCREEN_H, or where the y sum overflows, still take their cycle.
//   - For those pixels plot=0, so pass timing is unchanged.
//  FRAME_PAINTER_CLIP_EN undefined: y wraps mod 2^Y_W and every pixel is plotted.
// STRUCTURE
//  - painter_pkg: colour constants (RED/GREEN/BLACK), state encoding, pass-length function.
//  - Sub-module rect_walker: given origin, width, height and a start strobe,
//    steps (dx,dy) one per cycle.
//    It asserts last on the final pixel. Used for the box and for each pipe.
//    A pipe index counter selects the snapshot slice.
// TESTING
//  1 reset; key_press=1 at cycle 5 -> LATCH at cycle 6.
//    Then 99 plot cycles: first 9 RED at x 4..6, y 20..22 (box_y=20); then 90 GREEN.
//  2 pipe_x={200,120,40}, pipe_y={50,30,10} -> pipe 0 plots x=40, y=10..39 in order.
//    Pipes 1 and 2 follow, each contiguous.
//  3 Change box_y/pipe_y during WAIT, then game_pulse -> 99 BLACK pixels equal the DRAW
//    coordinates; frame_done pulses once.
//  4 game_pulse during DRAW pixel 50 -> no WAIT dwell. ERASE starts 1 cycle after the last
//    DRAW pixel.
//  5 collided=1 at DONE -> START, busy=0, plot=0. key_press restarts.
//    collided=0 -> LATCH the next cycle.
//  6 pipe_y=110: with CLIP_EN, rows 110..119 plotted, 20 cycles plot=0.
//    Without CLIP_EN, y wraps 127 -> 0..11. Reset asserted mid-DRAW -> plot=0 the same cycle.

Source files
------------

// File: rtl/frame_painter_pkg.sv
// Shared definitions for frame_painter: colour constants, FSM states and pass sizing helpers.
package frame_painter_pkg;

    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLACK = 3'b000;

    typedef enum logic [2:0] {
        ST_START,
        ST_LATCH,
        ST_DRAW,
        ST_WAIT,
        ST_ERASE,
        ST_DONE
    } state_t;

    function automatic int unsigned pass_len(input int unsigned box, input int unsigned pipes,
                                             input int unsigned pw, input int unsigned pl);
        return box * box + pipes * pw * pl;
    endfunction

    // Bits needed to hold the largest rectangle edge (the value itself, not just the offset).
    function automatic int unsigned dim_w(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/frame_painter_if.sv
// Game-logic / VGA-adapter signal bundle for frame_painter.
interface frame_painter_if #(
    parameter int unsigned NUM_PIPES = 3,
    parameter int unsigned X_W       = 9,
    parameter int unsigned Y_W       = 7
);
    logic                     key_press;
    logic                     game_pulse;
    logic                     collided;
    logic [Y_W-1:0]           box_y;
    logic [NUM_PIPES*X_W-1:0] pipe_x;
    logic [NUM_PIPES*Y_W-1:0] pipe_y;
    logic                     plot;
    logic [X_W-1:0]           x;
    logic [Y_W-1:0]           y;
    logic [2:0]               colour;
    logic                     frame_done;
    logic                     busy;

    modport master (
        output key_press, game_pulse, collided, box_y, pipe_x, pipe_y,
        input  plot, x, y, colour, frame_done, busy
    );

    modport slave (
        input  key_press, game_pulse, collided, box_y, pipe_x, pipe_y,
        output plot, x, y, colour, frame_done, busy
    );
endinterface

// File: rtl/frame_painter_rect_walker.sv
// Rectangle offset stepper: one (dx,dy) per step, row- or column-major, wraps to 0 after last.
module rect_walker #(
    parameter int unsigned D_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           step,
    input  logic           col_major,
    input  logic [D_W-1:0] width,
    input  logic [D_W-1:0] height,
    output logic [D_W-1:0] dx,
    output logic [D_W-1:0] dy,
    output logic           last
);
    logic x_end, y_end;

    always_comb begin
        x_end = (dx == width - D_W'(1));
        y_end = (dy == height - D_W'(1));
        last  = x_end && y_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx <= '0;
            dy <= '0;
        end else if (clear) begin
            dx <= '0;
            dy <= '0;
        end else if (step) begin
            if (last) begin
                dx <= '0;
                dy <= '0;
            end else if (col_major) begin
                if (y_end) begin
                    dy <= '0;
                    dx <= dx + D_W'(1);
                end else begin
                    dy <= dy + D_W'(1);
                end
            end else begin
                if (x_end) begin
                    dx <= '0;
                    dy <= dy + D_W'(1);
                end else begin
                    dx <= dx + D_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/frame_painter.sv
// Paints the player box and NUM_PIPES pipes each frame, waits for the game tick, then erases them.
// Build option: define FRAME_PAINTER_CLIP_EN to suppress plot for rows at or below SCREEN_H.
module frame_painter
    import frame_painter_pkg::*;
#(
    parameter int unsigned NUM_PIPES = 3,
    parameter int unsigned PIPE_LEN  = 30,
    parameter int unsigned PIPE_W    = 1,
    parameter int unsigned BOX_SIZE  = 3,
    parameter int unsigned BOX_X     = 4,
    parameter int unsigned X_W       = 9,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned SCREEN_H  = 120
) (
    input logic           CLOCK_50,
    input logic           reset,
    frame_painter_if.slave bus
);
    localparam int unsigned D_W      = dim_w(BOX_SIZE, PIPE_W, PIPE_LEN);
    localparam int unsigned SEG_W    = $clog2(NUM_PIPES + 1);
    localparam int unsigned PASS_LEN = pass_len(BOX_SIZE, NUM_PIPES, PIPE_W, PIPE_LEN);
    localparam int unsigned CNT_W    = $clog2(PASS_LEN);
`ifdef FRAME_PAINTER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    state_t                   state;
    logic                     tick_pending, out_last;
    logic [Y_W-1:0]           snap_box_y;
    logic [NUM_PIPES*X_W-1:0] snap_px;
    logic [NUM_PIPES*Y_W-1:0] snap_py;
    logic [SEG_W-1:0]         seg;
    logic [CNT_W-1:0]         pix_cnt;
    logic [D_W-1:0]           dx, dy, rw, rh;
    logic                     wlast, col_major, tick, consume, emit_draw, emit_erase;
    logic                     step, final_px, clear_cursor, visible;
    logic [X_W-1:0]           base_x, px;
    logic [Y_W-1:0]           base_y, py;
    logic [Y_W:0]             y_sum;
    logic [2:0]               pcol;
    int unsigned              pi;

    // The cursor (seg, dx, dy) always names the pixel registered on the next emitting edge.
    // Pixel 0 leaves on the LATCH edge, so it takes box_y live; it equals the value snapped then.
    always_comb begin
        tick         = bus.game_pulse | tick_pending;
        emit_draw    = (state == ST_LATCH) || (state == ST_DRAW && !out_last);
        consume      = tick && ((state == ST_DRAW && out_last) || state == ST_WAIT);
        emit_erase   = consume || (state == ST_ERASE && !out_last);
        step         = emit_draw || emit_erase;
        final_px     = (pix_cnt == CNT_W'(PASS_LEN - 1));
        clear_cursor = (state == ST_START);
        pi           = (seg == '0) ? 0 : 32'(seg) - 32'd1;
        if (seg == '0) begin
            col_major = 1'b0;
            rw        = D_W'(BOX_SIZE);
            rh        = D_W'(BOX_SIZE);
            base_x    = X_W'(BOX_X);
            base_y    = (state == ST_LATCH) ? bus.box_y : snap_box_y;
            pcol      = RED;
        end else begin
            col_major = 1'b1;
            rw        = D_W'(PIPE_W);
            rh        = D_W'(PIPE_LEN);
            base_x    = snap_px[pi*X_W +: X_W];
            base_y    = snap_py[pi*Y_W +: Y_W];
            pcol      = GREEN;
        end
        px      = base_x + X_W'(dx);
        y_sum   = {1'b0, base_y} + (Y_W+1)'(dy);
        py      = y_sum[Y_W-1:0];
        visible = !CLIP || (y_sum < (Y_W+1)'(SCREEN_H));
    end

    rect_walker #(.D_W(D_W)) u_walker (
        .clk       (CLOCK_50),
        .rst       (reset),
        .clear     (clear_cursor),
        .step      (step),
        .col_major (col_major),
        .width     (rw),
        .height    (rh),
        .dx        (dx),
        .dy        (dy),
        .last      (wlast)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            seg     <= '0;
            pix_cnt <= '0;
        end else if (clear_cursor) begin
            seg     <= '0;
            pix_cnt <= '0;
        end else if (step) begin
            pix_cnt <= final_px ? '0 : pix_cnt + CNT_W'(1);
            if (wlast) seg <= final_px ? '0 : seg + SEG_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state          <= ST_START;
            bus.plot       <= 1'b0;
            bus.x          <= '0;
            bus.y          <= '0;
            bus.colour     <= BLACK;
            bus.frame_done <= 1'b0;
            bus.busy       <= 1'b0;
            tick_pending   <= 1'b0;
            out_last       <= 1'b0;
            snap_box_y     <= '0;
            snap_px        <= '0;
            snap_py        <= '0;
        end else begin
            bus.plot       <= 1'b0;
            bus.frame_done <= 1'b0;
            out_last       <= step && final_px;
            if (step) begin
                bus.plot   <= visible;
                bus.x      <= px;
                bus.y      <= py;
                bus.colour <= emit_erase ? BLACK : pcol;
            end
            if (consume)
                tick_pending <= 1'b0;
            else if (bus.game_pulse && state != ST_START)
                tick_pending <= 1'b1;

            unique case (state)
                ST_START: begin
                    bus.busy <= 1'b0;
                    if (bus.key_press) begin
                        state    <= ST_LATCH;
                        bus.busy <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    snap_box_y <= bus.box_y;
                    snap_px    <= bus.pipe_x;
                    snap_py    <= bus.pipe_y;
                    state      <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (out_last) begin
                        if (tick) begin
                            state <= ST_ERASE;
                        end else begin
                            state    <= ST_WAIT;
                            bus.busy <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (tick) begin
                        state    <= ST_ERASE;
                        bus.busy <= 1'b1;
                    end
                end
                ST_ERASE: begin
                    if (out_last) begin
                        state          <= ST_DONE;
                        bus.busy       <= 1'b0;
                        bus.frame_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.collided) begin
                        state <= ST_START;
                    end else begin
                        state    <= ST_LATCH;
                        bus.busy <= 1'b1;
                    end
                end
                default: state <= ST_START;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_painter.sv
// Self-checking bench for frame_painter: per-pixel comparison against a pass list built from
// the box/pipe geometry of the latched frame.
module tb_frame_painter;
    import frame_painter_pkg::*;

    localparam int unsigned NP = 3;
    localparam int unsigned PL = 30;
    localparam int unsigned PW = 1;
    localparam int unsigned BS = 3;
    localparam int unsigned BX = 4;
    localparam int unsigned XW = 9;
    localparam int unsigned YW = 7;
    localparam int unsigned SH = 120;
    localparam int unsigned P  = BS * BS + NP * PW * PL;
`ifdef FRAME_PAINTER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    typedef struct packed {
        logic          plot;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [2:0]    c;
    } pix_t;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    always #10 CLOCK_50 = ~CLOCK_50;

    frame_painter_if #(.NUM_PIPES(NP), .X_W(XW), .Y_W(YW)) bus ();

    frame_painter #(
        .NUM_PIPES(NP), .PIPE_LEN(PL), .PIPE_W(PW), .BOX_SIZE(BS), .BOX_X(BX),
        .X_W(XW), .Y_W(YW), .SCREEN_H(SH)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int unsigned m_box_y;
    int unsigned m_px [NP];
    int unsigned m_py [NP];
    pix_t        exp_q[$];

    task automatic cycle();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic apply_model();
        bus.box_y = YW'(m_box_y);
        for (int i = 0; i < NP; i++) begin
            bus.pipe_x[i*XW +: XW] = XW'(m_px[i]);
            bus.pipe_y[i*YW +: YW] = YW'(m_py[i]);
        end
    endtask

    task automatic randomize_model();
        m_box_y = $urandom_range(0, 127);
        for (int i = 0; i < NP; i++) begin
            m_px[i] = $urandom_range(0, 511);
            m_py[i] = $urandom_range(0, 127);
        end
    endtask

    task automatic scramble_inputs();
        bus.box_y = YW'($urandom);
        for (int i = 0; i < NP; i++) begin
            bus.pipe_x[i*XW +: XW] = XW'($urandom);
            bus.pipe_y[i*YW +: YW] = YW'($urandom);
        end
    endtask

    function automatic void push_pix(int unsigned xs, int unsigned ys, logic [2:0] c);
        pix_t e;
        e.plot = CLIP ? (ys < SH) : 1'b1;
        e.x    = XW'(xs % (1 << XW));
        e.y    = YW'(ys % (1 << YW));
        e.c    = c;
        exp_q.push_back(e);
    endfunction

    // Geometry of one pass: box rows top to bottom, then each pipe column by column.
    function automatic void build_expected(bit erase);
        exp_q.delete();
        for (int r = 0; r < BS; r++)
            for (int c = 0; c < BS; c++)
                push_pix(BX + c, m_box_y + r, erase ? BLACK : RED);
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < PW; c++)
                for (int r = 0; r < PL; r++)
                    push_pix(m_px[p] + c, m_py[p] + r, erase ? BLACK : GREEN);
    endfunction

    task automatic check_pass(string name, bit erase, int pulse_at, bit scramble);
        pix_t e;
        build_expected(erase);
        for (int k = 0; k < P; k++) begin
            cycle();
            e = exp_q[k];
            checks++;
            if ({bus.plot, bus.busy, bus.frame_done} !== {e.plot, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL %s px%0d ctrl: plot/busy/done got %b want %b", name, k,
                         {bus.plot, bus.busy, bus.frame_done}, {e.plot, 1'b1, 1'b0});
            end
            if (e.plot) begin
                checks++;
                if ({bus.x, bus.y, bus.colour} !== {e.x, e.y, e.c}) begin
                    errors++;
                    $display("FAIL %s px%0d pixel: got x=%0d y=%0d c=%b want x=%0d y=%0d c=%b",
                             name, k, bus.x, bus.y, bus.colour, e.x, e.y, e.c);
                end
            end
            bus.game_pulse = (k == pulse_at);
            if (scramble) scramble_inputs();
        end
        bus.game_pulse = 1'b0;
    endtask

    task automatic check_idle(string name, int n);
        for (int k = 0; k < n; k++) begin
            cycle();
            checks++;
            if ({bus.plot, bus.busy, bus.frame_done} !== 3'b000) begin
                errors++;
                $display("FAIL %s idle%0d: plot/busy/done got %b want 000", name, k,
                         {bus.plot, bus.busy, bus.frame_done});
            end
            bus.game_pulse = 1'b0;
        end
    endtask

    task automatic check_latch(string name);
        checks++;
        if ({bus.plot, bus.busy, bus.frame_done} !== 3'b010) begin
            errors++;
            $display("FAIL %s latch: plot/busy/done got %b want 010", name,
                     {bus.plot, bus.busy, bus.frame_done});
        end
    endtask

    task automatic start_frame(string name);
        bus.key_press = 1'b1;
        cycle();
        bus.key_press = 1'b0;
        check_latch(name);
    endtask

    task automatic check_done(string name, bit collide);
        cycle();
        checks++;
        if ({bus.plot, bus.busy, bus.frame_done} !== 3'b001) begin
            errors++;
            $display("FAIL %s done: plot/busy/done got %b want 001", name,
                     {bus.plot, bus.busy, bus.frame_done});
        end
        bus.collided = collide;
        cycle();
        bus.collided = 1'b0;
        checks++;
        if ({bus.plot, bus.busy, bus.frame_done} !== {1'b0, !collide, 1'b0}) begin
            errors++;
            $display("FAIL %s after_done: plot/busy/done got %b want %b", name,
                     {bus.plot, bus.busy, bus.frame_done}, {1'b0, !collide, 1'b0});
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.key_press  = 1'b0;
        bus.game_pulse = 1'b0;
        bus.collided   = 1'b0;
        bus.box_y      = '0;
        bus.pipe_x     = '0;
        bus.pipe_y     = '0;
        cycle();
        checks++;
        if ({bus.plot, bus.x, bus.y, bus.colour, bus.frame_done, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_state: plot=%b x=%0d y=%0d c=%b done=%b busy=%b want all 0",
                     bus.plot, bus.x, bus.y, bus.colour, bus.frame_done, bus.busy);
        end
        reset = 1'b0;
        check_idle("start_idle", 1);
        bus.game_pulse = 1'b1;           // ignored in START
        check_idle("start_pulse", 3);
    endtask

    task automatic test_draw_box_pipes();
        m_box_y = 20;
        m_px[0] = 40;  m_px[1] = 120; m_px[2] = 200;
        m_py[0] = 10;  m_py[1] = 30;  m_py[2] = 50;
        apply_model();
        start_frame("first");
        check_pass("first_draw", 1'b0, -1, 1'b0);
        check_idle("wait_dwell", 5);
    endtask

    task automatic test_erase_snapshot();
        scramble_inputs();
        check_idle("wait_changed", 2);
        bus.game_pulse = 1'b1;
        check_pass("first_erase", 1'b1, -1, 1'b0);
        check_done("first", 1'b0);
    endtask

    task automatic test_back_to_back();
        randomize_model();
        apply_model();
        check_pass("b2b_draw", 1'b0, 50, 1'b1);
        check_pass("b2b_erase", 1'b1, -1, 1'b0);
        check_done("b2b", 1'b1);
    endtask

    task automatic test_collide_restart();
        bus.game_pulse = 1'b1;
        check_idle("collide_start", 3);
        randomize_model();
        apply_model();
        start_frame("restart");
        check_pass("restart_draw", 1'b0, -1, 1'b1);
        check_idle("restart_wait", 3);
        bus.game_pulse = 1'b1;
        check_pass("restart_erase", 1'b1, -1, 1'b0);
        check_done("restart", 1'b0);
    endtask

    task automatic test_wrap_and_reset();
        randomize_model();
        m_box_y = 125;
        m_py[0] = 110;
        apply_model();
        check_pass("wrap_draw", 1'b0, -1, 1'b0);
        check_idle("wrap_wait", 1);
        bus.game_pulse = 1'b1;
        check_pass("wrap_erase", 1'b1, -1, 1'b0);
        check_done("wrap", 1'b0);
        randomize_model();
        apply_model();
        for (int k = 0; k < 30; k++) cycle();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.plot, bus.busy, bus.frame_done} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset: plot/busy/done got %b want 000",
                     {bus.plot, bus.busy, bus.frame_done});
        end
        cycle();
        reset = 1'b0;
        check_idle("post_reset", 4);
        randomize_model();
        apply_model();
        start_frame("post_reset");
        check_pass("post_reset_draw", 1'b0, -1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_draw_box_pipes();
        test_erase_snapshot();
        test_back_to_back();
        test_collide_restart();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
